// File: rtl/cache_pkg.sv
// Shared types and default widths for the 2-way write-back cache controller.
package cache_pkg;

  localparam int TAG_W_DEF  = 3;
  localparam int IDX_W_DEF  = 2;
  localparam int DATA_W_DEF = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_WBACK,
    ST_REFILL,
    ST_RESP
  } state_t;

  // Per-slot status flags; the tag lives alongside in a width-parameterised array.
  typedef struct packed {
    logic valid;
    logic dirty;
  } meta_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/cache_tag_store.sv
// Per-slot valid/dirty/tag storage plus one LRU bit per set; provides hit and
// victim selection for the set currently being looked up.
module cache_tag_store
  import cache_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [IDX_W-1:0] set_idx,
  input  logic [TAG_W-1:0] lk_tag,
  output logic             hit,
  output logic             hit_way,
  output logic             victim_way,
  output logic             victim_valid,
  output logic             victim_dirty,
  output logic [TAG_W-1:0] victim_tag,
  input  logic             upd_way,
  input  logic             touch_en,
  input  logic             wr_en,
  input  meta_t            wr_meta,
  input  logic [TAG_W-1:0] wr_tag
);

  localparam int SETS  = 1 << IDX_W;
  localparam int SLOTS = 2 * SETS;

  meta_t            meta_q [SLOTS];
  meta_t            meta_d [SLOTS];
  logic [TAG_W-1:0] tag_q  [SLOTS];
  logic [TAG_W-1:0] tag_d  [SLOTS];
  logic [SETS-1:0]  lru_q, lru_d;

  logic [IDX_W:0] slot0, slot1, slot_v, slot_u;
  logic           hit0, hit1;

  assign slot0 = {set_idx, 1'b0};
  assign slot1 = {set_idx, 1'b1};
  assign slot_u = {set_idx, upd_way};

  assign hit0    = meta_q[slot0].valid && (tag_q[slot0] == lk_tag);
  assign hit1    = meta_q[slot1].valid && (tag_q[slot1] == lk_tag);
  assign hit     = hit0 || hit1;
  assign hit_way = !hit0;

  // Fill an empty way before evicting; way 0 is preferred when both are empty.
  always_comb begin
    victim_way = lru_q[set_idx];
    if (!meta_q[slot0].valid) begin
      victim_way = 1'b0;
    end else if (!meta_q[slot1].valid) begin
      victim_way = 1'b1;
    end
  end

  assign slot_v       = {set_idx, victim_way};
  assign victim_valid = meta_q[slot_v].valid;
  assign victim_dirty = meta_q[slot_v].dirty;
  assign victim_tag   = tag_q[slot_v];

  always_comb begin
    meta_d = meta_q;
    tag_d  = tag_q;
    lru_d  = lru_q;
    if (wr_en) begin
      meta_d[slot_u] = wr_meta;
      tag_d[slot_u]  = wr_tag;
    end
    if (touch_en) begin
      lru_d[set_idx] = !upd_way;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SLOTS; i++) begin
        meta_q[i] <= '0;
        tag_q[i]  <= '0;
      end
      lru_q <= '0;
    end else begin
      meta_q <= meta_d;
      tag_q  <= tag_d;
      lru_q  <= lru_d;
    end
  end

endmodule

// File: rtl/cache_controller.sv
// 2-way set-associative write-back, write-allocate cache controller with an
// external data array. Optional hit/miss counters behind CACHE_STATS_EN.
module cache_controller
  import cache_pkg::*;
#(
  parameter int TAG_W  = TAG_W_DEF,
  parameter int IDX_W  = IDX_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   cpu_req,
  input  logic                   cpu_wren,
  input  logic [TAG_W+IDX_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0]      cpu_wdata,
  output logic                   cpu_ready,
  output logic                   cpu_done,
  output logic                   cpu_hit,
  output logic [DATA_W-1:0]      cpu_rdata,
  output logic                   arr_we,
  output logic [IDX_W:0]         arr_idx,
  output logic [DATA_W-1:0]      arr_wdata,
  input  logic [DATA_W-1:0]      arr_rdata,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [TAG_W+IDX_W-1:0] mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic [DATA_W-1:0]      mem_rdata,
  input  logic                   mem_ack
`ifdef CACHE_STATS_EN
  ,
  output logic [7:0]             hit_count,
  output logic [7:0]             miss_count
`endif
);

  localparam int ADDR_W = TAG_W + IDX_W;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wren_q, wren_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                hit_q, hit_d;
  logic                way_q, way_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  logic [IDX_W-1:0]    set_idx;
  logic [TAG_W-1:0]    req_tag;
  logic                ts_hit, ts_hit_way;
  logic                ts_victim_way, ts_victim_valid, ts_victim_dirty;
  logic [TAG_W-1:0]    ts_victim_tag;
  logic                upd_way, touch_en, wr_en;
  meta_t               wr_meta;

  assign set_idx = addr_q[IDX_W-1:0];
  assign req_tag = addr_q[ADDR_W-1:IDX_W];

  cache_tag_store #(
    .TAG_W (TAG_W),
    .IDX_W (IDX_W)
  ) u_tag_store (
    .clock        (clock),
    .reset_n      (reset_n),
    .set_idx      (set_idx),
    .lk_tag       (req_tag),
    .hit          (ts_hit),
    .hit_way      (ts_hit_way),
    .victim_way   (ts_victim_way),
    .victim_valid (ts_victim_valid),
    .victim_dirty (ts_victim_dirty),
    .victim_tag   (ts_victim_tag),
    .upd_way      (upd_way),
    .touch_en     (touch_en),
    .wr_en        (wr_en),
    .wr_meta      (wr_meta),
    .wr_tag       (req_tag)
  );

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wren_d        = wren_q;
    wdata_d       = wdata_q;
    hit_d         = hit_q;
    way_d         = way_q;
    rdata_d       = rdata_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    arr_we        = 1'b0;
    arr_idx       = {set_idx, way_q};
    arr_wdata     = wdata_q;
    upd_way       = way_q;
    touch_en      = 1'b0;
    wr_en         = 1'b0;
    wr_meta.valid = 1'b1;
    wr_meta.dirty = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (cpu_req) begin
          addr_d  = cpu_addr;
          wren_d  = cpu_wren;
          wdata_d = cpu_wdata;
          state_d = ST_LOOKUP;
        end
      end

      ST_LOOKUP: begin
        hit_d = ts_hit;
        if (ts_hit) begin
          way_d    = ts_hit_way;
          arr_idx  = {set_idx, ts_hit_way};
          upd_way  = ts_hit_way;
          touch_en = 1'b1;
          if (wren_q) begin
            arr_we = 1'b1;
            wr_en  = 1'b1;
          end else begin
            rdata_d = arr_rdata;
          end
          state_d = ST_RESP;
        end else begin
          way_d   = ts_victim_way;
          arr_idx = {set_idx, ts_victim_way};
          upd_way = ts_victim_way;
          if (ts_victim_valid && ts_victim_dirty) begin
            // arr_idx points at the victim, so arr_rdata is the line to write back.
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = {ts_victim_tag, set_idx};
            mem_wdata_d = arr_rdata;
            state_d     = ST_WBACK;
          end else if (!wren_q) begin
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = addr_q;
            state_d    = ST_REFILL;
          end else begin
            arr_we   = 1'b1;
            wr_en    = 1'b1;
            touch_en = 1'b1;
            state_d  = ST_RESP;
          end
        end
      end

      ST_WBACK: begin
        if (mem_ack) begin
          mem_wdata_d = '0;
          if (wren_q) begin
            arr_we     = 1'b1;
            wr_en      = 1'b1;
            touch_en   = 1'b1;
            mem_req_d  = 1'b0;
            mem_we_d   = 1'b0;
            mem_addr_d = '0;
            state_d    = ST_RESP;
          end else begin
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = addr_q;
            state_d    = ST_REFILL;
          end
        end
      end

      ST_REFILL: begin
        if (mem_ack) begin
          arr_we        = 1'b1;
          arr_wdata     = mem_rdata;
          wr_en         = 1'b1;
          wr_meta.dirty = 1'b0;
          touch_en      = 1'b1;
          rdata_d       = mem_rdata;
          mem_req_d     = 1'b0;
          mem_we_d      = 1'b0;
          mem_addr_d    = '0;
          mem_wdata_d   = '0;
          state_d       = ST_RESP;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wren_q      <= 1'b0;
      wdata_q     <= '0;
      hit_q       <= 1'b0;
      way_q       <= 1'b0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wren_q      <= wren_d;
      wdata_q     <= wdata_d;
      hit_q       <= hit_d;
      way_q       <= way_d;
      rdata_q     <= rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign cpu_ready = (state_q == ST_IDLE);
  assign cpu_done  = (state_q == ST_RESP);
  assign cpu_hit   = hit_q;
  assign cpu_rdata = rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

`ifdef CACHE_STATS_EN
  logic [7:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == ST_RESP) begin
      if (hit_q) hit_cnt_d = sat_inc8(hit_cnt_q);
      else       miss_cnt_d = sat_inc8(miss_cnt_q);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Directed self-checking bench for cache_controller with a behavioural data array
// and a hand-driven memory responder.
module tb_cache_controller;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       cpu_req = 1'b0;
  logic       cpu_wren = 1'b0;
  logic [4:0] cpu_addr = '0;
  logic [2:0] cpu_wdata = '0;
  logic       cpu_ready, cpu_done, cpu_hit;
  logic [2:0] cpu_rdata;
  logic       arr_we;
  logic [2:0] arr_idx;
  logic [2:0] arr_wdata, arr_rdata;
  logic       mem_req, mem_we;
  logic [4:0] mem_addr;
  logic [2:0] mem_wdata;
  logic [2:0] mem_rdata = '0;
  logic       mem_ack = 1'b0;
`ifdef CACHE_STATS_EN
  logic [7:0] hit_count, miss_count;
`endif

  int tests = 0;
  int fails = 0;

  logic [2:0] darr [8];

  always #5 clock = ~clock;

  assign arr_rdata = darr[arr_idx];
  always @(posedge clock) if (arr_we) darr[arr_idx] <= arr_wdata;

  cache_controller dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .cpu_req   (cpu_req),
    .cpu_wren  (cpu_wren),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ready (cpu_ready),
    .cpu_done  (cpu_done),
    .cpu_hit   (cpu_hit),
    .cpu_rdata (cpu_rdata),
    .arr_we    (arr_we),
    .arr_idx   (arr_idx),
    .arr_wdata (arr_wdata),
    .arr_rdata (arr_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
`ifdef CACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  // Stimulus helpers: they only drive and wait, callers do the checking.
  task automatic issue(input logic wr, input logic [4:0] a, input logic [2:0] d);
    @(negedge clock);
    cpu_req = 1'b1; cpu_wren = wr; cpu_addr = a; cpu_wdata = d;
    @(posedge clock);
    #1 cpu_req = 1'b0;
  endtask

  task automatic wait_done(output logic done, output int cyc, output logic saw_mem);
    done = 1'b0; cyc = 0; saw_mem = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      cyc++;
      if (mem_req) saw_mem = 1'b1;
      if (cpu_done) begin
        done = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_mem(output logic got);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (mem_req) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic ack_mem(input int hold, input logic [2:0] rd, input logic poke, output logic stable);
    logic       we0;
    logic [4:0] a0;
    logic [2:0] d0;
    we0 = mem_we; a0 = mem_addr; d0 = mem_wdata; stable = 1'b1;
    if (poke) begin
      cpu_req = 1'b1; cpu_wren = 1'b0; cpu_addr = 5'b11111;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      cpu_req = 1'b0;
      if (!mem_req || mem_we !== we0 || mem_addr !== a0 || mem_wdata !== d0) stable = 1'b0;
    end
    mem_ack = 1'b1; mem_rdata = rd;
    @(posedge clock);
    #1 mem_ack = 1'b0; mem_rdata = '0;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 8; i++) darr[i] = '0;
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    tests++; if (cpu_done !== 1'b0) begin fails++; $display("FAIL reset_cpu_done got=%b exp=0", cpu_done); end
    tests++; if (cpu_hit !== 1'b0) begin fails++; $display("FAIL reset_cpu_hit got=%b exp=0", cpu_hit); end
    tests++; if (cpu_rdata !== 3'b000) begin fails++; $display("FAIL reset_cpu_rdata got=%b exp=000", cpu_rdata); end
    tests++; if (arr_we !== 1'b0) begin fails++; $display("FAIL reset_arr_we got=%b exp=0", arr_we); end
    tests++; if ({mem_req, mem_we} !== 2'b00) begin fails++; $display("FAIL reset_mem_req_we got=%b exp=00", {mem_req, mem_we}); end
    tests++; if ({mem_addr, mem_wdata} !== 8'h00) begin fails++; $display("FAIL reset_mem_addr_wdata got=%h exp=00", {mem_addr, mem_wdata}); end
    reset_n = 1'b1;
    @(negedge clock);
    tests++; if (cpu_ready !== 1'b1) begin fails++; $display("FAIL reset_cpu_ready got=%b exp=1", cpu_ready); end
  endtask

  task automatic test_read_miss;
    logic got, done, saw, stable;
    int   cyc;
    issue(1'b0, 5'b00101, 3'b000);
    wait_mem(got);
    tests++; if (!got) begin fails++; $display("FAIL rmiss_mem_req got=timeout exp=request"); end
    tests++; if ({mem_we, mem_addr} !== {1'b0, 5'b00101}) begin fails++; $display("FAIL rmiss_mem_addr got=%b/%b exp=0/00101", mem_we, mem_addr); end
    ack_mem(2, 3'b110, 1'b0, stable);
    tests++; if (!stable) begin fails++; $display("FAIL rmiss_mem_stable got=unstable exp=stable"); end
    wait_done(done, cyc, saw);
    tests++; if (!done || cyc != 1) begin fails++; $display("FAIL rmiss_done got=%b/%0d exp=1/1", done, cyc); end
    tests++; if ({cpu_hit, cpu_rdata} !== 4'b0110) begin fails++; $display("FAIL rmiss_resp got=%b/%b exp=0/110", cpu_hit, cpu_rdata); end
    tests++; if (darr[2] !== 3'b110) begin fails++; $display("FAIL rmiss_array got=%b exp=110", darr[2]); end
    @(negedge clock);
    tests++; if (cpu_done !== 1'b0) begin fails++; $display("FAIL rmiss_done_pulse got=%b exp=0", cpu_done); end
  endtask

  task automatic test_read_hit;
    logic done, saw;
    int   cyc;
    issue(1'b0, 5'b00101, 3'b000);
    wait_done(done, cyc, saw);
    tests++; if (!done || cyc != 2) begin fails++; $display("FAIL rhit_latency got=%b/%0d exp=1/2", done, cyc); end
    tests++; if ({cpu_hit, cpu_rdata} !== 4'b1110) begin fails++; $display("FAIL rhit_resp got=%b/%b exp=1/110", cpu_hit, cpu_rdata); end
    tests++; if (saw !== 1'b0) begin fails++; $display("FAIL rhit_no_mem got=%b exp=0", saw); end
  endtask

  task automatic test_write_evict;
    logic done, saw, got, stable;
    int   cyc;
    issue(1'b1, 5'b00001, 3'b011);
    wait_done(done, cyc, saw);
    tests++; if (!done || cyc != 2 || saw || cpu_hit !== 1'b0) begin fails++; $display("FAIL wmiss_clean got=%b/%0d/%b/%b exp=1/2/0/0", done, cyc, saw, cpu_hit); end
    tests++; if (darr[3] !== 3'b011) begin fails++; $display("FAIL wmiss_array got=%b exp=011", darr[3]); end
    issue(1'b1, 5'b00101, 3'b011);
    wait_done(done, cyc, saw);
    tests++; if (!done || cyc != 2 || saw || cpu_hit !== 1'b1) begin fails++; $display("FAIL whit got=%b/%0d/%b/%b exp=1/2/0/1", done, cyc, saw, cpu_hit); end
    tests++; if (darr[2] !== 3'b011) begin fails++; $display("FAIL whit_array got=%b exp=011", darr[2]); end
    issue(1'b1, 5'b01001, 3'b011);
    wait_mem(got);
    tests++; if (!got) begin fails++; $display("FAIL wback_req got=timeout exp=request"); end
    tests++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 5'b00001, 3'b011}) begin fails++; $display("FAIL wback_fields got=%b/%b/%b exp=1/00001/011", mem_we, mem_addr, mem_wdata); end
    ack_mem(3, 3'b000, 1'b1, stable);
    tests++; if (!stable) begin fails++; $display("FAIL wback_stable got=unstable exp=stable"); end
    wait_done(done, cyc, saw);
    tests++; if (!done || cyc != 1 || cpu_hit !== 1'b0) begin fails++; $display("FAIL wback_done got=%b/%0d/%b exp=1/1/0", done, cyc, cpu_hit); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      tests++; if ({cpu_ready, cpu_done, mem_req} !== 3'b100) begin fails++; $display("FAIL wback_poke_ignored got=%b exp=100", {cpu_ready, cpu_done, mem_req}); end
    end
  endtask

  task automatic test_spurious_ack;
    logic done, saw;
    int   cyc;
    @(negedge clock);
    mem_ack = 1'b1; mem_rdata = 3'b111;
    @(negedge clock);
    mem_ack = 1'b0; mem_rdata = '0;
    @(negedge clock);
    tests++; if ({cpu_ready, cpu_done, mem_req, arr_we} !== 4'b1000) begin fails++; $display("FAIL spur_ack_idle got=%b exp=1000", {cpu_ready, cpu_done, mem_req, arr_we}); end
    issue(1'b0, 5'b01001, 3'b000);
    wait_done(done, cyc, saw);
    tests++; if (!done || cyc != 2 || saw || {cpu_hit, cpu_rdata} !== 4'b1011) begin fails++; $display("FAIL spur_ack_hit got=%b/%0d/%b/%b/%b exp=1/2/0/1/011", done, cyc, saw, cpu_hit, cpu_rdata); end
  endtask

  task automatic test_dirty_read_miss;
    logic got, done, saw, stable;
    int   cyc;
    issue(1'b0, 5'b00001, 3'b000);
    wait_mem(got);
    tests++; if (!got || {mem_we, mem_addr, mem_wdata} !== {1'b1, 5'b00101, 3'b011}) begin fails++; $display("FAIL drm_wback got=%b/%b/%b/%b exp=1/1/00101/011", got, mem_we, mem_addr, mem_wdata); end
    ack_mem(1, 3'b000, 1'b0, stable);
    wait_mem(got);
    tests++; if (!got || {mem_we, mem_addr} !== {1'b0, 5'b00001}) begin fails++; $display("FAIL drm_refill got=%b/%b/%b exp=1/0/00001", got, mem_we, mem_addr); end
    ack_mem(1, 3'b100, 1'b0, stable);
    wait_done(done, cyc, saw);
    tests++; if (!done || cyc != 1 || {cpu_hit, cpu_rdata} !== 4'b0100) begin fails++; $display("FAIL drm_resp got=%b/%0d/%b/%b exp=1/1/0/100", done, cyc, cpu_hit, cpu_rdata); end
    tests++; if (darr[2] !== 3'b100) begin fails++; $display("FAIL drm_array got=%b exp=100", darr[2]); end
  endtask

  task automatic test_reset_mid;
    logic got, done, saw, stable;
    int   cyc;
    issue(1'b0, 5'b10010, 3'b000);
    wait_mem(got);
    tests++; if (!got || mem_addr !== 5'b10010) begin fails++; $display("FAIL rstmid_refill got=%b/%b exp=1/10010", got, mem_addr); end
    reset_n = 1'b0;
    #1;
    tests++; if ({mem_req, mem_addr, cpu_ready} !== {1'b0, 5'b00000, 1'b1}) begin fails++; $display("FAIL rstmid_abort got=%b/%b/%b exp=0/00000/1", mem_req, mem_addr, cpu_ready); end
    @(negedge clock);
    reset_n = 1'b1;
    issue(1'b0, 5'b01001, 3'b000);
    wait_mem(got);
    tests++; if (!got || {mem_we, mem_addr} !== {1'b0, 5'b01001}) begin fails++; $display("FAIL rstmid_meta_cleared got=%b/%b/%b exp=1/0/01001", got, mem_we, mem_addr); end
    ack_mem(1, 3'b101, 1'b0, stable);
    wait_done(done, cyc, saw);
    tests++; if (!done || {cpu_hit, cpu_rdata} !== 4'b0101) begin fails++; $display("FAIL rstmid_resp got=%b/%b/%b exp=1/0/101", done, cpu_hit, cpu_rdata); end
  endtask

  task automatic test_back_to_back;
    logic done, saw;
    int   cyc;
    for (int i = 0; i < 2; i++) begin
      issue(1'b0, 5'b01001, 3'b000);
      wait_done(done, cyc, saw);
      tests++; if (!done || cyc != 2 || saw || {cpu_hit, cpu_rdata} !== 4'b1101) begin fails++; $display("FAIL b2b_hit%0d got=%b/%0d/%b/%b/%b exp=1/2/0/1/101", i, done, cyc, saw, cpu_hit, cpu_rdata); end
    end
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_read_hit();
    test_write_evict();
    test_spurious_ack();
    test_dirty_read_miss();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 SHALL have parameter TAG_W, default 3, meaning address tag width.
REQ-002 SHALL have parameter IDX_W, default 2, meaning set index width (4 sets, 2 ways).
REQ-003 SHALL have parameter DATA_W, default 3, meaning word width.
REQ-004 SHALL have ports as below; one clock; reset is asynchronous and active-low.
- clock  in  1  rising-edge clock
- reset_n  in  1  async active-low reset
- cpu_req  in  1  CPU request valid
- cpu_wren  in  1  1=write, 0=read
- cpu_addr  in  TAG_W+IDX_W  word address {tag,index}
- cpu_wdata  in  DATA_W  write data
- cpu_ready  out  1  controller idle, request acceptable
- cpu_done  out  1  one-cycle completion pulse
- cpu_hit  out  1  hit status of completed access, valid with cpu_done
- cpu_rdata  out  DATA_W  read data, valid with cpu_done
- arr_we  out  1  data-array write enable
- arr_idx  out  IDX_W+1  data-array slot {index,way}
- arr_wdata  out  DATA_W  data-array write data
- arr_rdata  in  DATA_W  data-array combinational read of arr_idx
- mem_req  out  1  main-memory request, held until mem_ack
- mem_we  out  1  1=write-back, 0=refill read
- mem_addr  out  TAG_W+IDX_W  main-memory word address
- mem_wdata  out  DATA_W  write-back data
- mem_rdata  in  DATA_W  refill data, valid with mem_ack
- mem_ack  in  1  one-cycle memory completion

Function
REQ-005 SHALL hold per-slot metadata valid, dirty, tag (8 slots) and one LRU bit per set (way that is least recently used).
REQ-006 SHALL implement FSM states IDLE, LOOKUP, WBACK, REFILL, RESP.
REQ-007 IDLE: cpu_ready=1; cpu_req=1 at an edge captures wren/addr/wdata, goes to LOOKUP; cpu_req while not IDLE ignored.
REQ-008 LOOKUP: hit = valid & tag match in either way; way 0 takes precedence if both match.
REQ-009 Read hit: cpu_rdata=arr_rdata of hit slot, LRU points to other way, -> RESP.
REQ-010 Write hit: arr_we=1 one cycle in LOOKUP, dirty=1, LRU updated, -> RESP.
REQ-011 Miss: victim = first invalid way (way 0 first), else LRU way; victim valid & dirty -> WBACK, else read -> REFILL, write -> RESP with arr_we in LOOKUP.
REQ-012 WBACK: mem_req=1, mem_we=1, mem_addr={victim tag,index}, mem_wdata=victim data, stable until mem_ack; on ack read -> REFILL, write -> RESP after writing data.
REQ-013 REFILL: mem_req=1, mem_we=0, mem_addr=cpu_addr; on mem_ack write mem_rdata to victim slot, cpu_rdata=mem_rdata, valid=1, dirty=0.
REQ-014 Write miss: victim gets cpu_wdata, valid=1, dirty=1 (write-allocate, no refill).
REQ-015 Every completed access sets LRU to the non-accessed way.
REQ-016 RESP: cpu_done=1 for exactly one cycle, cpu_hit reflects LOOKUP result, -> IDLE.
REQ-017 Latency edge accept->cpu_done: hit 2 cycles; clean miss = 2 + memory wait; dirty read miss = two memory transactions.
REQ-018 mem_ack outside WBACK/REFILL SHALL be ignored.

Reset
REQ-019 reset_n=0 SHALL immediately force IDLE, clear all valid/dirty/LRU bits, drive cpu_done, cpu_hit, cpu_rdata, arr_we, mem_req, mem_we, mem_addr, mem_wdata to 0, cpu_ready to 1 after release.
REQ-020 Reset mid-transaction SHALL abort it with no metadata retained.

Configuration
REQ-021 With CACHE_STATS_EN defined: outputs hit_count[7:0], miss_count[7:0], saturating at 255, incremented at RESP, cleared by reset; without it those ports and counters do not exist.

Structure
REQ-022 cache_pkg SHALL hold the FSM state typedef, width constants and metadata record type.
REQ-023 Metadata storage with victim/LRU selection SHALL be sub-module cache_tag_store.

Verification
REQ-024 After reset, read addr 5'b00101 -> REFILL mem_addr=5'b00101; ack data 3'b110 -> cpu_done, cpu_hit=0, cpu_rdata=3'b110.
REQ-025 Repeat read 5'b00101 -> cpu_done 2 cycles after accept, cpu_hit=1, cpu_rdata=3'b110, no mem_req.
REQ-026 Write 3'b011 to 5'b00001, 5'b00101, 5'b01001 (same set 01) -> third evicts LRU 5'b00001: WBACK mem_addr=5'b00001, mem_wdata=3'b011.
REQ-027 Assert reset_n=0 during REFILL with mem_req high -> mem_req=0 same cycle; next read of same address misses.
REQ-028 cpu_req pulsed during WBACK and spurious mem_ack in IDLE -> both ignored, no state change.
